hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Parametrised successor of the ID-stage stall detector for the RV32I pipeline.
- Replaces fixed EX/ME address compares with a small age-indexed scoreboard of in-flight register writers.
- Supports configurable ALU and load result latencies and data-memory wait freezes.
- Adds a stall-cause output and a saturating stall performance counter. Sits beside the ID stage and drives the PC/IF-ID hold and the ID/EX bubble insert.

Parameters:
- REG_AW, 5, register address width.
- ALU_LAT, 1, cycles from entering EX until an ALU result can be bypassed to an ID-stage (branch/jalr) consumer; 1 <= ALU_LAT <= LOAD_LAT.
- LOAD_LAT, 2, same measure for load results; also the scoreboard depth D.
- CNT_W, 32, stall counter width.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- dmem_ready_i  in  1  data memory ready; 0 freezes the whole pipeline this cycle
- flush_i  in  1  instruction currently in ID is being killed (taken branch/jump)
- id_valid_i  in  1  ID holds a valid instruction
- rs1_addr_ID_i  in  REG_AW  ID source 1
- rs2_addr_ID_i  in  REG_AW  ID source 2
- rs1_used_ID_i  in  1  ID instruction reads rs1
- rs2_used_ID_i  in  1  ID instruction reads rs2
- Branch_ID_i  in  1  ID instruction is a conditional branch (operands consumed in ID)
- Jalr_ID_i  in  1  ID instruction is jalr (rs1 consumed in ID)
- rd_addr_ID_i  in  REG_AW  ID destination
- RegWrite_ID_i  in  1  ID instruction writes rd
- MemRead_ID_i  in  1  ID instruction is a load
- stall_o  out  1  hold IF/ID, insert bubble into EX
- stall_cause_o  out  2  00 none, 01 ALU->branch, 10 load->use, 11 load->branch
- stall_cnt_o  out  CNT_W  stall cycle count

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous and active-low on rst_n_i.
- Scoreboard storage: shift register of D=LOAD_LAT slots, each slot {valid, rd, is_load}. Slot k holds the writer that entered EX k cycles ago (slot 0 = currently in EX).
- Remaining latency of slot k: rem = (is_load ? LOAD_LAT : ALU_LAT) - k. A slot with rem <= 0 never causes a stall.
- Advance: adv = dmem_ready_i & id_valid_i & ~stall_o & ~flush_i.
- Shift rule: on each clk_i edge with dmem_ready_i=1, the register shifts by one. Slot 0 loads {adv & RegWrite_ID_i & (rd_addr_ID_i!=0), rd_addr_ID_i, MemRead_ID_i}; otherwise it loads an invalid bubble.
- Freeze: with dmem_ready_i=0 the register and counter hold.
- Match: slot k matches source s when valid, used_s=1, rd==addr_s, and addr_s != 0. x0 never matches.
- Slack: 0 when Branch_ID_i | Jalr_ID_i, else 1. Jalr considers rs1 only.
- stall_o (combinational) = id_valid_i & ~flush_i & (any matching slot with rem > slack). Multiple matches for the same rd (WAW) stall conservatively if any one qualifies.
- stall_cause_o is the classification of the qualifying slot with largest rem; ties go to the lowest k. Classes: load & slack 0 -> 11; load & slack 1 -> 10; ALU -> 01. It is 00 when stall_o=0.
- Default latencies reproduce the legacy detector:
  - ALU in EX -> branch: 1 stall cycle.
  - Load in EX -> ALU use: 1 stall cycle.
  - Load in EX -> branch: 2 stall cycles.
  - Load in ME -> branch: 1 stall cycle.
- stall_cnt_o increments on each edge where stall_o & dmem_ready_i, and saturates at all-ones.
- Reset mid-operation: all slots invalid, counter 0, hence stall_o=0 and stall_cause_o=00 immediately (asynchronous).
- Flush while stalled: stall_o drops the same cycle; the flushed instruction is never inserted.

Test Plan:
- add x5 issues, next cycle beq x5,x0 in ID -> stall_o=1, cause 01 for 1 cycle, then 0; stall_cnt_o=1.
- lw x7 issues, next add x8,x7,x1 -> stall_o=1, cause 10 for exactly 1 cycle.
- lw x7 issues, next beq x7,x2 -> stall_o=1 for 2 cycles (cause 11 both); stall_cnt_o=2. Repeat with LOAD_LAT=3 -> 3 cycles.
- lw x0 followed by beq x0,x0; and lw x9 followed by lui x9 (rs1/rs2_used=0) -> stall_o never asserts.
- lw x7 then beq x7 with dmem_ready_i=0 for 3 cycles mid-stall -> stall_o held, counter frozen. After ready returns, total stall edges with ready=1 equals 2.
- Counter preloaded near saturation (CNT_W=4, 15 stalls then 3 more) -> stall_cnt_o stays 15.
- Assert rst_n_i low during load stall -> stall_o=0 and stall_cnt_o=0 without a clock edge.
- flush_i=1 during load->branch stall -> stall_o=0 the same cycle, no slot inserted.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// ID-stage stall detector for the RV32I pipeline. It keeps a small age-indexed
// scoreboard of in-flight register writers. Slot k holds the writer that
// entered EX k cycles ago. A writer's result reaches an ID-stage consumer
// (branch/jalr) after ALU_LAT or LOAD_LAT cycles, and reaches an EX-stage
// consumer one cycle sooner than that. The unit reports stalls, the cause of
// each stall, and a saturating count of stalled cycles.
//
// Ports:
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   dmem_ready_i        0 freezes the pipeline (scoreboard and counter hold)
//   flush_i             the instruction in ID is being killed
//   id_valid_i          ID holds a valid instruction
//   rs1/rs2_addr_ID_i   ID source registers
//   rs1/rs2_used_ID_i   ID instruction reads rs1/rs2
//   Branch_ID_i         conditional branch (operands consumed in ID)
//   Jalr_ID_i           jalr (only rs1 consumed, in ID)
//   rd_addr_ID_i        ID destination register
//   RegWrite_ID_i       ID instruction writes rd
//   MemRead_ID_i        ID instruction is a load
//   stall_o             hold PC and IF/ID, insert a bubble into ID/EX
//   stall_cause_o       00 none, 01 ALU->branch, 10 load->use, 11 load->branch
//   stall_cnt_o         saturating count of stalled, non-frozen cycles
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              dmem_ready_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] rs1_addr_ID_i,
  input  logic [REG_AW-1:0] rs2_addr_ID_i,
  input  logic              rs1_used_ID_i,
  input  logic              rs2_used_ID_i,
  input  logic              Branch_ID_i,
  input  logic              Jalr_ID_i,
  input  logic [REG_AW-1:0] rd_addr_ID_i,
  input  logic              RegWrite_ID_i,
  input  logic              MemRead_ID_i,
  output logic              stall_o,
  output logic [1:0]        stall_cause_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // The deepest writer (a load) is tracked until its result can be bypassed
  // to ID, so the scoreboard needs exactly LOAD_LAT slots.
  localparam int D = LOAD_LAT;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              is_load;
  } slot_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_ALU_BR   = 2'b01,
    CAUSE_LOAD_USE = 2'b10,
    CAUSE_LOAD_BR  = 2'b11
  } cause_e;

  slot_t [D-1:0]    sb_q, sb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  int     slack;      // cycles the consumer can still wait: 0 in ID, 1 in EX
  logic   rs1_chk;
  logic   rs2_chk;
  int     rem_k;
  logic   match_k;
  logic   any_hit;
  int     best_rem;
  logic   best_load;
  logic   stall;
  logic   adv;
  cause_e cause;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default before any
  // conditional logic, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    slack     = (Branch_ID_i | Jalr_ID_i) ? 0 : 1;
    rs1_chk   = rs1_used_ID_i & (rs1_addr_ID_i != '0);
    // jalr reads rs1 only; x0 never creates a dependency.
    rs2_chk   = rs2_used_ID_i & ~Jalr_ID_i & (rs2_addr_ID_i != '0);
    rem_k     = 0;
    match_k   = 1'b0;
    any_hit   = 1'b0;
    best_rem  = 0;
    best_load = 1'b0;

    for (int k = 0; k < D; k++) begin
      rem_k   = (sb_q[k].is_load ? LOAD_LAT : ALU_LAT) - k;
      match_k = sb_q[k].valid &
                ((rs1_chk & (sb_q[k].rd == rs1_addr_ID_i)) |
                 (rs2_chk & (sb_q[k].rd == rs2_addr_ID_i)));
      if (match_k && (rem_k > slack)) begin
        // Strict compare keeps the lowest k on equal remaining latency.
        if (!any_hit || (rem_k > best_rem)) begin
          best_rem  = rem_k;
          best_load = sb_q[k].is_load;
        end
        any_hit = 1'b1;
      end
    end

    stall = id_valid_i & ~flush_i & any_hit;

    cause = CAUSE_NONE;
    if (stall) begin
      if (!best_load)      cause = CAUSE_ALU_BR;
      else if (slack == 0) cause = CAUSE_LOAD_BR;
      else                 cause = CAUSE_LOAD_USE;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard shift and stall counter next state
  // ---------------------------------------------------------------------------
  always_comb begin
    sb_d  = sb_q;
    cnt_d = cnt_q;
    adv   = dmem_ready_i & id_valid_i & ~stall & ~flush_i;

    if (dmem_ready_i) begin
      for (int k = 1; k < D; k++) begin
        sb_d[k] = sb_q[k-1];
      end
      // A stalled or flushed instruction does not enter EX: slot 0 gets a bubble.
      sb_d[0].valid   = adv & RegWrite_ID_i & (rd_addr_ID_i != '0);
      sb_d[0].rd      = rd_addr_ID_i;
      sb_d[0].is_load = MemRead_ID_i;

      if (stall && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values and the shift happens in one step.
  // NOTE: the scoreboard is a small flop array, so it is reset along with the
  // counter; that makes stall_o drop the moment rst_n_i asserts.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_o       = stall;
  assign stall_cause_o = cause;
  assign stall_cnt_o   = cnt_q;

endmodule
